// File: rtl/johnson_phase_monitor_if.sv
// Bus between a Johnson counter source and johnson_phase_monitor.
// The source drives the code, valid and clear; the monitor returns phase and status.
interface johnson_phase_monitor_if #(
  parameter int REV_W = 8
);
  logic             jc_valid;
  logic [3:0]       jc_in;
  logic             err_clr;
  logic [2:0]       phase;
  logic [7:0]       phase_oh;
  logic             locked;
  logic             rev_tick;
  logic [REV_W-1:0] rev_count;
  logic             err_illegal;
  logic             err_seq;
  logic             err_sticky;

  modport master (
    output jc_valid, jc_in, err_clr,
    input  phase, phase_oh, locked, rev_tick, rev_count,
           err_illegal, err_seq, err_sticky
  );

  modport slave (
    input  jc_valid, jc_in, err_clr,
    output phase, phase_oh, locked, rev_tick, rev_count,
           err_illegal, err_seq, err_sticky
  );
endinterface

// File: rtl/johnson_phase_monitor.sv
// Decodes and sequence-checks a 4-bit Johnson counter, declares lock, counts revolutions.
// JOHNSON_MON_AUTO_RELOCK_EN: when defined, ERROR re-enters LOCKING on the next legal code.
module johnson_phase_monitor #(
  parameter int REV_W    = 8,
  parameter int LOCK_CNT = 4
) (
  input logic                   clk,
  input logic                   rst,
  johnson_phase_monitor_if.slave mon
);
  localparam int GW = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {IDLE, LOCKING, LOCKED, ERROR} state_t;

  state_t           state;
  logic [GW-1:0]    good_cnt;
  logic [2:0]       phase;
  logic [7:0]       phase_oh;
  logic             locked;
  logic             rev_tick;
  logic [REV_W-1:0] rev_count;
  logic             err_illegal;
  logic             err_seq;
  logic             err_sticky;

  logic             code_legal;
  logic [2:0]       code_idx;
  logic             is_succ;
  logic [7:0]       code_oh;

  always_comb begin
    code_legal = 1'b1;
    code_idx   = '0;
    case (mon.jc_in)
      4'b0000: code_idx = 3'd0;
      4'b1000: code_idx = 3'd1;
      4'b1100: code_idx = 3'd2;
      4'b1110: code_idx = 3'd3;
      4'b1111: code_idx = 3'd4;
      4'b0111: code_idx = 3'd5;
      4'b0011: code_idx = 3'd6;
      4'b0001: code_idx = 3'd7;
      default: code_legal = 1'b0;
    endcase
    // phase always holds the last legal code, so it doubles as the previous code
    is_succ = code_legal && (code_idx == phase + 3'd1);
    code_oh = 8'b1 << code_idx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      good_cnt    <= '0;
      phase       <= '0;
      phase_oh    <= '0;
      locked      <= 1'b0;
      rev_tick    <= 1'b0;
      rev_count   <= '0;
      err_illegal <= 1'b0;
      err_seq     <= 1'b0;
      err_sticky  <= 1'b0;
    end else begin
      rev_tick    <= 1'b0;
      err_illegal <= 1'b0;
      err_seq     <= 1'b0;
      if (mon.err_clr) begin
        state      <= IDLE;
        good_cnt   <= '0;
        phase_oh   <= '0;
        locked     <= 1'b0;
        rev_count  <= '0;
        err_sticky <= 1'b0;
      end else if (mon.jc_valid) begin
        case (state)
          IDLE: begin
            if (code_legal) begin
              state    <= LOCKING;
              good_cnt <= '0;
              phase    <= code_idx;
              phase_oh <= code_oh;
            end else begin
              state       <= ERROR;
              err_illegal <= 1'b1;
              err_sticky  <= 1'b1;
            end
          end
          LOCKING: begin
            if (!code_legal) begin
              state       <= ERROR;
              phase_oh    <= '0;
              err_illegal <= 1'b1;
              err_sticky  <= 1'b1;
            end else begin
              phase    <= code_idx;
              phase_oh <= code_oh;
              if (is_succ) begin
                good_cnt <= good_cnt + 1'b1;
                if (int'(good_cnt) + 1 >= LOCK_CNT) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                end
              end else begin
                good_cnt   <= '0;
                err_seq    <= 1'b1;
                err_sticky <= 1'b1;
              end
            end
          end
          LOCKED: begin
            if (is_succ) begin
              phase    <= code_idx;
              phase_oh <= code_oh;
              if (code_idx == 3'd0) begin
                rev_count <= rev_count + 1'b1;
                rev_tick  <= 1'b1;
              end
            end else begin
              state      <= ERROR;
              locked     <= 1'b0;
              phase_oh   <= '0;
              err_sticky <= 1'b1;
              if (code_legal) begin
                phase   <= code_idx;
                err_seq <= 1'b1;
              end else begin
                err_illegal <= 1'b1;
              end
            end
          end
          ERROR: begin
`ifdef JOHNSON_MON_AUTO_RELOCK_EN
            if (code_legal) begin
              state    <= LOCKING;
              good_cnt <= '0;
              phase    <= code_idx;
              phase_oh <= code_oh;
            end
`endif
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign mon.phase       = phase;
  assign mon.phase_oh    = phase_oh;
  assign mon.locked      = locked;
  assign mon.rev_tick    = rev_tick;
  assign mon.rev_count   = rev_count;
  assign mon.err_illegal = err_illegal;
  assign mon.err_seq     = err_seq;
  assign mon.err_sticky  = err_sticky;
endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Directed scenarios followed by randomized traffic, checked against a rule-level model.
module tb_johnson_phase_monitor;
  localparam int REV_W    = 8;
  localparam int LOCK_CNT = 4;

  logic clk;
  logic rst;
  int   n_err;
  int   n_chk;

  johnson_phase_monitor_if #(.REV_W(REV_W)) bus ();

  johnson_phase_monitor #(.REV_W(REV_W), .LOCK_CNT(LOCK_CNT)) dut (
    .clk (clk),
    .rst (rst),
    .mon (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [3:0] ph_code [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                              4'b1111, 4'b0111, 4'b0011, 4'b0001};

  // model: 0 idle, 1 acquiring, 2 locked, 3 error
  int m_mode, m_phase, m_good, m_rev;
  bit m_tick, m_ill, m_seq, m_sticky;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int lookup(input logic [3:0] c);
    for (int i = 0; i < 8; i++)
      if (ph_code[i] == c) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_phase = 0; m_good = 0; m_rev = 0;
    m_tick = 0; m_ill = 0; m_seq = 0; m_sticky = 0;
  endtask

  task automatic model_clock(input bit v, input logic [3:0] c, input bit clr);
    int  k;
    bit  legal, succ, upd;
    m_tick = 0; m_ill = 0; m_seq = 0;
    if (clr) begin
      m_mode = 0; m_good = 0; m_rev = 0; m_sticky = 0;
      return;
    end
    if (!v) return;
    k     = lookup(c);
    legal = (k >= 0);
    succ  = legal && (k == (m_phase + 1) % 8);
    upd   = legal;
    case (m_mode)
      0: if (legal) begin m_mode = 1; m_good = 0; end
         else begin m_ill = 1; m_mode = 3; end
      1: if (!legal) begin m_ill = 1; m_mode = 3; end
         else if (succ) begin
           m_good++;
           if (m_good == LOCK_CNT) m_mode = 2;
         end else begin m_seq = 1; m_good = 0; end
      2: if (succ) begin
           if (k == 0) begin m_rev = (m_rev + 1) % (1 << REV_W); m_tick = 1; end
         end else begin
           if (legal) m_seq = 1; else m_ill = 1;
           m_mode = 3;
         end
      default: begin
`ifdef JOHNSON_MON_AUTO_RELOCK_EN
        if (legal) begin m_mode = 1; m_good = 0; end
`else
        upd = 0;
`endif
      end
    endcase
    if (upd) m_phase = k;
    if (m_ill || m_seq) m_sticky = 1;
  endtask

  task automatic check_outputs();
    logic [31:0] exp_oh;
    exp_oh = (m_mode == 1 || m_mode == 2) ? (32'd1 << m_phase) : 32'd0;
    check("phase",       32'(bus.phase),       32'(m_phase));
    check("phase_oh",    32'(bus.phase_oh),    exp_oh);
    check("locked",      32'(bus.locked),      32'(m_mode == 2));
    check("rev_tick",    32'(bus.rev_tick),    32'(m_tick));
    check("rev_count",   32'(bus.rev_count),   32'(m_rev));
    check("err_illegal", 32'(bus.err_illegal), 32'(m_ill));
    check("err_seq",     32'(bus.err_seq),     32'(m_seq));
    check("err_sticky",  32'(bus.err_sticky),  32'(m_sticky));
  endtask

  task automatic step(input bit v, input logic [3:0] c, input bit clr);
    bus.jc_valid = v;
    bus.jc_in    = c;
    bus.err_clr  = clr;
    @(posedge clk);
    model_clock(v, c, clr);
    #1;
    check_outputs();
  endtask

  task automatic feed_seq(input int start, input int n);
    for (int i = 0; i < n; i++) step(1'b1, ph_code[(start + i) % 8], 1'b0);
  endtask

  initial begin
    logic [3:0] c;
    bit         v, clr;
    int         r;
    n_err = 0;
    n_chk = 0;
    rst = 1'b0;
    bus.jc_valid = 1'b0;
    bus.jc_in    = '0;
    bus.err_clr  = 1'b0;
    model_reset();
    #12;
    check_outputs();
    #5 rst = 1'b1;

    // acquisition: locked one clock after 1111
    feed_seq(0, 5);
    check("s1_locked", 32'(bus.locked), 32'd1);
    check("s1_phase", 32'(bus.phase), 32'd4);
    check("s1_oh", 32'(bus.phase_oh), 32'h10);

    // two revolutions, then on to 256 total for the wrap
    feed_seq(5, 16);
    check("s2_rev2", 32'(bus.rev_count), 32'd2);
    feed_seq(5, 8 * 254);
    check("s2_wrap", 32'(bus.rev_count), 32'd0);

    // illegal code while locked at 1100
    feed_seq(5, 6);
    step(1'b1, 4'b1010, 1'b0);
    check("s3_ill", 32'(bus.err_illegal), 32'd1);
    check("s3_sticky", 32'(bus.err_sticky), 32'd1);
    check("s3_locked", 32'(bus.locked), 32'd0);
    check("s3_oh", 32'(bus.phase_oh), 32'd0);
    check("s3_phase", 32'(bus.phase), 32'd2);
    step(1'b0, 4'b0000, 1'b0);
    check("s3_pulse1", 32'(bus.err_illegal), 32'd0);

    // clear wins over a simultaneous valid code
    step(1'b1, 4'b0000, 1'b1);
    check("s5_sticky", 32'(bus.err_sticky), 32'd0);
    check("s5_rev", 32'(bus.rev_count), 32'd0);
    check("s5_oh", 32'(bus.phase_oh), 32'd0);
    check("s5_phase", 32'(bus.phase), 32'd2);

    // skip from 1100 to 1111, then 0111 while in error
    feed_seq(0, 5);
    feed_seq(5, 6);
    step(1'b1, 4'b1111, 1'b0);
    check("s4_seq", 32'(bus.err_seq), 32'd1);
    check("s4_locked", 32'(bus.locked), 32'd0);
    step(1'b1, 4'b0111, 1'b0);
`ifdef JOHNSON_MON_AUTO_RELOCK_EN
    check("s4_relock_oh", 32'(bus.phase_oh), 32'h20);
`else
    check("s4_hold_oh", 32'(bus.phase_oh), 32'd0);
    check("s4_hold_phase", 32'(bus.phase), 32'd4);
`endif

    // async reset mid-cycle while locked
    step(1'b0, 4'b0000, 1'b1);
    feed_seq(0, 5);
    bus.jc_valid = 1'b0;
    #3 rst = 1'b0;
    #1 model_reset();
    check_outputs();
    check("s6_locked", 32'(bus.locked), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    feed_seq(0, 5);
    check("s6_relock", 32'(bus.locked), 32'd1);
    check("s6_oh", 32'(bus.phase_oh), 32'h10);

    // randomized traffic
    for (int n = 0; n < 2500; n++) begin
      clr = ($urandom_range(99) < 3);
      v   = 1'b1;
      r   = $urandom_range(99);
      if (r < 70)      c = ph_code[(m_phase + 1) % 8];
      else if (r < 78) c = ph_code[m_phase];
      else if (r < 86) c = ph_code[$urandom_range(7)];
      else if (r < 95) begin
        do c = 4'($urandom_range(15)); while (lookup(c) >= 0);
      end else begin
        v = 1'b0;
        c = 4'($urandom_range(15));
      end
      step(v, c, clr);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
